// File: rtl/life_pkg.sv
// Shared types and constants for the life_engine cellular-automaton core.
//   state_t        : engine FSM states
//   NB_DX / NB_DY  : neighbour offsets, visited in this order during UPDATE
//   BIRTH_B3 / SURVIVE_S23 : Conway's default rule masks
package life_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        UPDATE,
        SWAP
    } state_t;

    // Offsets as (dx,dy): (-1,+1),(0,+1),(+1,+1),(-1,0),(+1,0),(-1,-1),(0,-1),(+1,-1)
    localparam logic signed [1:0] NB_DX [8] = '{-2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1};
    localparam logic signed [1:0] NB_DY [8] = '{ 2'sd1, 2'sd1, 2'sd1,  2'sd0, 2'sd0, -2'sd1, -2'sd1, -2'sd1};

    localparam logic [8:0] BIRTH_B3    = 9'h008;
    localparam logic [8:0] SURVIVE_S23 = 9'h00C;

endpackage

// File: rtl/life_engine_if.sv
// Host/display bus of life_engine.
//   master : control side (start, randomize_req, rule masks, wrap_en, host write, display address)
//   slave  : engine side  (rd_cell, busy, done, generation, pop_count)
interface life_engine_if #(
    parameter int unsigned LOG_W = 5,
    parameter int unsigned LOG_H = 4
);
    logic                   start;
    logic                   randomize_req;
    logic [8:0]             birth_mask;
    logic [8:0]             survive_mask;
    logic                   wrap_en;
    logic                   wr_en;
    logic [LOG_W-1:0]       wr_x;
    logic [LOG_H-1:0]       wr_y;
    logic                   wr_data;
    logic [LOG_W-1:0]       rd_x;
    logic [LOG_H-1:0]       rd_y;
    logic                   rd_cell;
    logic                   busy;
    logic                   done;
    logic [15:0]            generation;
    logic [LOG_W+LOG_H:0]   pop_count;

    modport master (
        output start, randomize_req, birth_mask, survive_mask, wrap_en,
               wr_en, wr_x, wr_y, wr_data, rd_x, rd_y,
        input  rd_cell, busy, done, generation, pop_count
    );

    modport slave (
        input  start, randomize_req, birth_mask, survive_mask, wrap_en,
               wr_en, wr_x, wr_y, wr_data, rd_x, rd_y,
        output rd_cell, busy, done, generation, pop_count
    );

endinterface

// File: rtl/life_lfsr.sv
// 16-bit Fibonacci LFSR (taps 15,13,12,10) used to randomise the board.
//   i_clk, i_rst : clock, asynchronous active-high reset (loads SEED)
//   o_bit        : current bit 0; the register advances every cycle
module life_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_bit
);

    logic [15:0] r_lfsr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign o_bit = r_lfsr[0];

endmodule

// File: rtl/life_engine.sv
// Parametrised Game-of-Life engine with double-buffered board.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : life_engine_if.slave (control, host write, display read, status)
// Optional macro LIFE_POPCOUNT_EN: maintain pop_count of the displayed bank;
// when undefined pop_count is tied to zero.
module life_engine
    import life_pkg::*;
#(
    parameter int unsigned LOG_W     = 5,
    parameter int unsigned LOG_H     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         reset,
    life_engine_if.slave bus
);

    localparam int unsigned LOG_N = LOG_W + LOG_H;
    localparam int unsigned N     = 1 << LOG_N;

    state_t           r_state;
    logic             r_act;
    logic [LOG_N-1:0] r_idx;
    logic [3:0]       r_phase;
    logic [3:0]       r_count;
    logic [8:0]       r_birth;
    logic [8:0]       r_survive;
    logic             r_wrap;
    logic             r_done;
    logic [15:0]      r_gen;
    logic [N-1:0]     r_bank [2];

    logic             w_lfsr_bit;
    logic [LOG_W-1:0] w_cx, w_nx;
    logic [LOG_H-1:0] w_cy, w_ny;
    logic signed [1:0] w_dx, w_dy;
    logic             w_nb_in;
    logic             w_nb;
    logic             w_cur;
    logic             w_next;
    logic             w_we;
    logic             w_wsel;
    logic [LOG_N-1:0] w_waddr;
    logic             w_wdata;

    life_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clk (clk),
        .i_rst (reset),
        .o_bit (w_lfsr_bit)
    );

    assign {w_cy, w_cx} = r_idx;

    // Neighbour of the current cell selected by r_phase; truncation gives wrap,
    // w_nb_in flags whether it is on the board for bounded mode.
    always_comb begin
        w_dx    = NB_DX[r_phase[2:0]];
        w_dy    = NB_DY[r_phase[2:0]];
        w_nx    = w_cx + LOG_W'(w_dx);
        w_ny    = w_cy + LOG_H'(w_dy);
        w_nb_in = !((w_dx[1] && w_cx == '0) || (w_dx == 2'sd1 && w_cx == '1) ||
                    (w_dy[1] && w_cy == '0) || (w_dy == 2'sd1 && w_cy == '1));
        w_nb    = r_bank[r_act][{w_ny, w_nx}] & (r_wrap | w_nb_in);
        w_cur   = r_bank[r_act][r_idx];
        w_next  = w_cur ? r_survive[r_count] : r_birth[r_count];
    end

    always_comb begin
        w_we    = 1'b0;
        w_wsel  = r_act;
        w_waddr = r_idx;
        w_wdata = w_lfsr_bit;
        case (r_state)
            INIT: w_we = 1'b1;
            IDLE: begin
                if (bus.wr_en && !bus.randomize_req && !bus.start) begin
                    w_we    = 1'b1;
                    w_waddr = {bus.wr_y, bus.wr_x};
                    w_wdata = bus.wr_data;
                end
            end
            UPDATE: begin
                if (r_phase == 4'd8) begin
                    w_we    = 1'b1;
                    w_wsel  = ~r_act;
                    w_wdata = w_next;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_bank[w_wsel][w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= INIT;
            r_act     <= 1'b0;
            r_idx     <= '0;
            r_phase   <= '0;
            r_count   <= '0;
            r_birth   <= BIRTH_B3;
            r_survive <= SURVIVE_S23;
            r_wrap    <= 1'b1;
            r_done    <= 1'b0;
            r_gen     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                INIT: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == '1) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_gen   <= '0;
                    end
                end
                IDLE: begin
                    if (bus.randomize_req) begin
                        r_state <= INIT;
                        r_idx   <= '0;
                    end else if (bus.start) begin
                        r_state   <= UPDATE;
                        r_idx     <= '0;
                        r_phase   <= '0;
                        r_birth   <= bus.birth_mask;
                        r_survive <= bus.survive_mask;
                        r_wrap    <= bus.wrap_en;
                    end
                end
                UPDATE: begin
                    // Phases 0..7 accumulate one neighbour each, phase 8 writes the result.
                    if (r_phase == 4'd8) begin
                        r_phase <= '0;
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == '1) begin
                            r_state <= SWAP;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                        r_count <= ((r_phase == 4'd0) ? 4'd0 : r_count) + {3'b000, w_nb};
                    end
                end
                SWAP: begin
                    r_act   <= ~r_act;
                    r_gen   <= r_gen + 1'b1;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef LIFE_POPCOUNT_EN
    logic [LOG_N:0] r_pop;
    logic [LOG_N:0] r_pop_acc;
    logic           w_old;

    assign w_old = r_bank[r_act][w_waddr];

    // Accumulator restarts at cell 0 of each INIT/UPDATE pass and is loaded at the end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pop     <= '0;
            r_pop_acc <= '0;
        end else begin
            case (r_state)
                INIT: begin
                    r_pop_acc <= ((r_idx == '0) ? '0 : r_pop_acc) + (LOG_N+1)'(w_lfsr_bit);
                    if (r_idx == '1) begin
                        r_pop <= r_pop_acc + (LOG_N+1)'(w_lfsr_bit);
                    end
                end
                UPDATE: begin
                    if (r_phase == 4'd8) begin
                        r_pop_acc <= ((r_idx == '0) ? '0 : r_pop_acc) + (LOG_N+1)'(w_next);
                    end
                end
                SWAP: r_pop <= r_pop_acc;
                IDLE: begin
                    if (w_we && (w_old != w_wdata)) begin
                        r_pop <= w_wdata ? r_pop + 1'b1 : r_pop - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pop_count = r_pop;
`else
    assign bus.pop_count = '0;
`endif

    assign bus.rd_cell    = r_bank[r_act][{bus.rd_y, bus.rd_x}];
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = r_done;
    assign bus.generation = r_gen;

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine: a board-level reference model (whole-board
// rule application, LFSR fill) is compared against the DUT every cycle, plus
// hand-computed expectations for reset fill, blinker, block, glider, rule change,
// ignored requests and reset during UPDATE.
module tb_life_engine;

    localparam int unsigned LOG_W = 5;
    localparam int unsigned LOG_H = 4;
    localparam int W = 32;
    localparam int H = 16;
    localparam int N = 512;
    localparam int UPD_CYCLES = 9 * N + 1;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int OP_INIT = 0;
    localparam int OP_IDLE = 1;
    localparam int OP_UPD  = 2;
`ifdef LIFE_POPCOUNT_EN
    localparam bit POP_EN = 1'b1;
`else
    localparam bit POP_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   scramble = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;

    life_engine_if #(.LOG_W(LOG_W), .LOG_H(LOG_H)) bus ();

    life_engine #(.LOG_W(LOG_W), .LOG_H(LOG_H), .LFSR_SEED(SEED)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_board [N];
    bit          m_next  [N];
    bit          m_known [N];
    int          m_op   = OP_INIT;
    int          m_cnt  = 0;
    logic [15:0] m_lfsr = SEED;
    logic [15:0] m_gen  = '0;
    int          m_pop  = 0;
    bit          m_done = 1'b0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic int count_board();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_board[i]);
        return c;
    endfunction

    function automatic void compute_next(input logic [8:0] bm, input logic [8:0] sm, input bit wrap);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int xx = x + dx;
                        int yy = y + dy;
                        if (dx == 0 && dy == 0) continue;
                        if (wrap) begin
                            xx = (xx + W) % W;
                            yy = (yy + H) % H;
                        end else if (xx < 0 || xx >= W || yy < 0 || yy >= H) begin
                            continue;
                        end
                        n += int'(m_board[yy * W + xx]);
                    end
                end
                m_next[y * W + x] = m_board[y * W + x] ? sm[n] : bm[n];
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [15:0] cur;
        int          a;
        if (reset) begin
            m_op   = OP_INIT;
            m_cnt  = 0;
            m_lfsr = SEED;
            m_gen  = '0;
            m_pop  = 0;
            m_done = 1'b0;
            for (int i = 0; i < N; i++) m_known[i] = 1'b0;
        end else begin
            m_done = 1'b0;
            cur    = m_lfsr;
            m_lfsr = lfsr_step(m_lfsr);
            if (m_op == OP_INIT) begin
                m_board[m_cnt] = cur[0];
                m_known[m_cnt] = 1'b1;
                m_cnt++;
                if (m_cnt == N) begin
                    m_op   = OP_IDLE;
                    m_done = 1'b1;
                    m_gen  = '0;
                    m_pop  = POP_EN ? count_board() : 0;
                end
            end else if (m_op == OP_UPD) begin
                m_cnt++;
                if (m_cnt == UPD_CYCLES) begin
                    m_board = m_next;
                    m_gen   = m_gen + 16'd1;
                    m_done  = 1'b1;
                    m_pop   = POP_EN ? count_board() : 0;
                    m_op    = OP_IDLE;
                end
            end else begin
                if (bus.randomize_req) begin
                    m_op  = OP_INIT;
                    m_cnt = 0;
                end else if (bus.start) begin
                    compute_next(bus.birth_mask, bus.survive_mask, bus.wrap_en);
                    m_op  = OP_UPD;
                    m_cnt = 0;
                end else if (bus.wr_en) begin
                    a = int'(bus.wr_y) * W + int'(bus.wr_x);
                    m_board[a] = bus.wr_data;
                    m_known[a] = 1'b1;
                    m_pop      = POP_EN ? count_board() : 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        int a;
        chk("busy", int'(bus.busy), int'(m_op != OP_IDLE));
        chk("done", int'(bus.done), int'(m_done));
        chk("generation", int'(bus.generation), int'(m_gen));
        chk("pop_count", int'(bus.pop_count), m_pop);
        a = int'(bus.rd_y) * W + int'(bus.rd_x);
        if (m_known[a]) chk("rd_cell", int'(bus.rd_cell), int'(m_board[a]));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
        bus.rd_x = LOG_W'($urandom);
        bus.rd_y = LOG_H'($urandom);
        if (scramble) begin
            bus.birth_mask   = 9'($urandom);
            bus.survive_mask = 9'($urandom);
            bus.wrap_en      = 1'($urandom);
        end
    endtask

    task automatic wait_done(input string nm, input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            tick();
            cycles++;
            if (bus.done) return;
        end
        n_checks++;
        n_err++;
        $display("FAIL %s: done not seen within %0d cycles", nm, budget);
    endtask

    task automatic host_write(input int x, input int y, input bit v);
        bus.wr_en   = 1'b1;
        bus.wr_x    = LOG_W'(x);
        bus.wr_y    = LOG_H'(y);
        bus.wr_data = v;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic clear_board();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                host_write(x, y, 1'b0);
    endtask

    task automatic expect_cell(input string nm, input int x, input int y, input bit v);
        bus.rd_x = LOG_W'(x);
        bus.rd_y = LOG_H'(y);
        #1;
        chk(nm, int'(bus.rd_cell), int'(v));
    endtask

    task automatic run_gen(input string nm, input logic [8:0] bm, input logic [8:0] sm, input bit wrap);
        int n;
        bus.birth_mask   = bm;
        bus.survive_mask = sm;
        bus.wrap_en      = wrap;
        bus.start        = 1'b1;
        tick();
        bus.start        = 1'b0;
        scramble         = 1'b1;
        wait_done(nm, UPD_CYCLES + 20, n);
        scramble         = 1'b0;
        chk({nm, "_len"}, n, UPD_CYCLES);
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.start = 1'b0; bus.randomize_req = 1'b0; bus.wr_en = 1'b0;
        bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = 1'b0;
        bus.rd_x = '0; bus.rd_y = '0;
        bus.birth_mask = 9'h008; bus.survive_mask = 9'h00C; bus.wrap_en = 1'b1;

        // Reset and initial LFSR fill: first cells are 1,1,1,1,0 from 16'hACE1.
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("reset_busy", int'(bus.busy), 1);
        chk("reset_gen", int'(bus.generation), 0);
        wait_done("init", N + 20, n);
        chk("init_len", n, N);
        chk("init_gen", int'(bus.generation), 0);
        expect_cell("lfsr_c0", 0, 0, 1'b1);
        expect_cell("lfsr_c1", 1, 0, 1'b1);
        expect_cell("lfsr_c2", 2, 0, 1'b1);
        expect_cell("lfsr_c3", 3, 0, 1'b1);
        expect_cell("lfsr_c4", 4, 0, 1'b0);

        // Blinker under B3/S23 with wrap.
        clear_board();
        host_write(3, 2, 1'b1); host_write(3, 3, 1'b1); host_write(3, 4, 1'b1);
        run_gen("blink1", 9'h008, 9'h00C, 1'b1);
        expect_cell("blink_h0", 2, 3, 1'b1);
        expect_cell("blink_h1", 3, 3, 1'b1);
        expect_cell("blink_h2", 4, 3, 1'b1);
        expect_cell("blink_v0", 3, 2, 1'b0);
        chk("blink_gen", int'(bus.generation), 1);
        chk("blink_pop", int'(bus.pop_count), POP_EN ? 3 : 0);
        run_gen("blink2", 9'h008, 9'h00C, 1'b1);
        expect_cell("blink_back0", 3, 2, 1'b1);
        expect_cell("blink_back1", 3, 4, 1'b1);
        expect_cell("blink_back2", 2, 3, 1'b0);

        // Corner block, bounded edges, 3 generations.
        clear_board();
        host_write(0, 0, 1'b1); host_write(0, 1, 1'b1); host_write(1, 0, 1'b1); host_write(1, 1, 1'b1);
        for (int g = 0; g < 3; g++) run_gen("block", 9'h008, 9'h00C, 1'b0);
        expect_cell("block_00", 0, 0, 1'b1);
        expect_cell("block_11", 1, 1, 1'b1);
        expect_cell("block_20", 2, 0, 1'b0);
        expect_cell("block_w", 31, 0, 1'b0);

        // Glider crossing the x=31 edge with wrap.
        clear_board();
        host_write(30, 5, 1'b1); host_write(31, 6, 1'b1);
        host_write(29, 7, 1'b1); host_write(30, 7, 1'b1); host_write(31, 7, 1'b1);
        for (int g = 0; g < 4; g++) run_gen("glider", 9'h008, 9'h00C, 1'b1);
        expect_cell("glider_07", 0, 7, 1'b1);
        expect_cell("glider_08", 0, 8, 1'b1);
        expect_cell("glider_318", 31, 8, 1'b1);
        expect_cell("glider_old", 30, 5, 1'b0);
        chk("glider_pop", int'(bus.pop_count), POP_EN ? 5 : 0);

        // Rule change: a dead cell with 6 neighbours.
        clear_board();
        for (int dx = -1; dx <= 1; dx++) begin
            host_write(10 + dx, 9, 1'b1);
            host_write(10 + dx, 11, 1'b1);
        end
        run_gen("b36", 9'h048, 9'h00C, 1'b1);
        expect_cell("b36_birth", 10, 10, 1'b1);
        clear_board();
        for (int dx = -1; dx <= 1; dx++) begin
            host_write(10 + dx, 9, 1'b1);
            host_write(10 + dx, 11, 1'b1);
        end
        run_gen("b3", 9'h008, 9'h00C, 1'b1);
        expect_cell("b3_nobirth", 10, 10, 1'b0);

        // Requests while busy must be ignored.
        bus.birth_mask = 9'h008; bus.survive_mask = 9'h00C; bus.wrap_en = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (n < UPD_CYCLES + 20) begin
            tick();
            n++;
            bus.start = 1'b0; bus.wr_en = 1'b0; bus.randomize_req = 1'b0;
            if (bus.done) break;
            if (n == 100) bus.start = 1'b1;
            if (n == 200) begin
                bus.wr_en = 1'b1; bus.wr_x = LOG_W'(20); bus.wr_y = LOG_H'(12); bus.wr_data = 1'b1;
            end
            if (n == 300) bus.randomize_req = 1'b1;
        end
        chk("ign_len", n, UPD_CYCLES);
        chk("ign_gen", int'(bus.generation), 12);
        expect_cell("ign_write", 20, 12, 1'b0);
        tick(); tick();
        chk("ign_idle", int'(bus.busy), 0);

        // Random phase: re-randomise, random writes, random rule.
        bus.randomize_req = 1'b1;
        tick();
        bus.randomize_req = 1'b0;
        wait_done("rand_init", N + 20, n);
        chk("rand_init_len", n, N);
        chk("rand_gen", int'(bus.generation), 0);
        for (int i = 0; i < 60; i++) host_write($urandom_range(W - 1), $urandom_range(H - 1), 1'($urandom));
        run_gen("rand_gen1", 9'($urandom), 9'($urandom), 1'($urandom));

        // Reset during UPDATE.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (1000) tick();
        reset = 1'b1;
        #1;
        chk("rst_busy", int'(bus.busy), 1);
        chk("rst_gen", int'(bus.generation), 0);
        tick();
        reset = 1'b0;
        wait_done("reinit", N + 20, n);
        chk("reinit_len", n, N);
        chk("reinit_gen", int'(bus.generation), 0);
        expect_cell("re_c0", 0, 0, 1'b1);
        expect_cell("re_c3", 3, 0, 1'b1);
        expect_cell("re_c4", 4, 0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/life_engine.md
Name: life_engine

Overview:
- Parametrised Conway-style cellular-automaton core that generalises the current fixed 8x16 Game of Life board.
- Adds the following over the current board:
  - Any power-of-two board size.
  - Programmable birth/survive rule.
  - Selectable toroidal or bounded edges.
  - Double-buffered state with a one-cycle bank swap instead of a full copy pass.
  - A host write port.
- Sits between the VGA pixel/cell-index logic (which reads cells through the display port) and top-level control inputs.

Parameters:
- LOG_W, 5, log2 of board width in cells.
- LOG_H, 4, log2 of board height in cells.
- LFSR_SEED, 16'hACE1, non-zero reset value of the randomiser LFSR (taps 15,13,12,10).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to compute one generation.
- randomize  in  1  single-cycle request to refill the board from the LFSR.
- birth_mask  in  9  bit n=1: dead cell with n live neighbours becomes live.
- survive_mask  in  9  bit n=1: live cell with n live neighbours stays live.
- wrap_en  in  1  1=toroidal edges, 0=out-of-board neighbours count as dead.
- wr_en  in  1  host cell write, honoured only in IDLE.
- wr_x  in  LOG_W  host write column.
- wr_y  in  LOG_H  host write row.
- wr_data  in  1  host write value.
- rd_x  in  LOG_W  display read column.
- rd_y  in  LOG_H  display read row.
- rd_cell  out  1  combinational value of (rd_x,rd_y) in the active bank.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when INIT or SWAP completes.
- generation  out  16  generations completed since reset/randomize; wraps at 16'hFFFF.
- pop_count  out  LOG_W+LOG_H+1  live cells in the active bank (see optional feature).

Behaviour:
- Storage: two banks of N=2^(LOG_W+LOG_H) bits. The bank select bit `act` chooses the displayed/read bank. Cell index = {y,x}.
- Reset values:
  - State=INIT, act=0, cell index=0, busy=1, done=0.
  - generation=0, pop_count=0, LFSR=LFSR_SEED.
  - Bank contents are undefined until INIT completes.
- States:
  - INIT: writes the LFSR bit 0 into act-bank[idx] each cycle; the LFSR advances every cycle in every state. After idx=N-1 -> IDLE, done=1, generation=0. Duration: N cycles.
  - IDLE: busy=0. Priority, highest first:
    1. randomize -> INIT.
    2. start -> UPDATE; birth_mask, survive_mask and wrap_en are captured into registers here.
    3. wr_en -> write act-bank[{wr_y,wr_x}].
  - UPDATE: per cell, 8 cycles accumulate neighbours in the order (-1,+1),(0,+1),(+1,+1),(-1,0),(+1,0),(-1,-1),(0,-1),(+1,-1). A 9th cycle writes next = cur ? survive_mask[n] : birth_mask[n] into the inactive bank. Duration: 9*N cycles. After the last cell -> SWAP.
  - SWAP: act toggles, generation increments, done=1, -> IDLE. Duration: 1 cycle.
- Edge handling:
  - Wrap mode: coordinates are taken modulo width/height by bit truncation.
  - Bounded mode: a neighbour whose x or y would underflow/overflow contributes 0.
  - Neighbour count is 4 bits, maximum 8.
- Display: rd_cell always reads the act bank, so the picture never tears during UPDATE. A change is visible in the cycle after SWAP.
- Ignored requests: start, randomize and wr_en are ignored while busy and are not queued. wr_en is also ignored in the same cycle as an accepted start or randomize.
- Mask changes during UPDATE have no effect, because the captured copies are used.
- Reset mid-operation immediately aborts, re-enters INIT and clears generation.

Optional Feature:
- Macro: LIFE_POPCOUNT_EN.
- Defined:
  - pop_count is recomputed during UPDATE by summing the next states written, and is loaded at SWAP.
  - INIT accumulates the written bits, loaded at completion.
  - Host writes adjust pop_count by +1/-1 only when the cell value changes.
- Undefined: pop_count is held at 0 and no counter logic is present.

Decomposition:
- Package life_pkg holds:
  - the state enum (INIT, IDLE, UPDATE, SWAP);
  - the neighbour dx/dy offset table (8 entries, 2-bit signed);
  - the Conway default masks BIRTH_B3=9'h008 and SURVIVE_S23=9'h00C.
- One sub-module, life_lfsr: 16-bit Fibonacci LFSR with seed parameter, async reset, output bit 0.

Test Plan:
- Reset: assert reset, release -> busy=1 for N=512 cycles, then done pulse, busy=0, generation=0; bank contents match the LFSR sequence from 16'hACE1.
- Blinker, B3/S23, wrap_en=1: write (3,2),(3,3),(3,4), start -> done after 9*512+1 cycles; live cells exactly (2,3),(3,3),(4,3); generation=1, pop_count=3; a second start restores the original cells.
- Edges: block at (0,0),(0,1),(1,0),(1,1) with wrap_en=0 -> unchanged after 3 generations. With wrap_en=1, a glider crossing the x=31 edge reappears at x=0 with 5 live cells.
- Rule change: B36/S23 (birth 9'h048), seed six-cell pattern where a dead cell has 6 neighbours -> that cell becomes live; under B3/S23 it stays dead.
- Ignored requests: start, wr_en and randomize pulsed mid-UPDATE -> no extra generation, board unaffected by the write, no re-init; rd_cell shows the old bank until SWAP.
- Reset mid-UPDATE: assert reset at cycle 1000 of UPDATE -> busy stays 1, INIT reruns from LFSR_SEED, generation=0.
